// File: rtl/falafel_pkg.sv
// Shared types for the falafel request arbiter: request entries, core ops, arbitration modes and states.
package falafel_pkg;

   localparam int ID_W   = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
   } alloc_entry_t;

   typedef enum logic {
      CORE_OP_ALLOC = 1'b0,
      CORE_OP_FREE  = 1'b1
   } core_op_e;

   typedef struct packed {
      core_op_e     op;
      alloc_entry_t entry;
   } core_req_t;

   typedef enum logic [1:0] {
      ARB_RR         = 2'd0,
      ARB_FREE_PRIO  = 2'd1,
      ARB_ALLOC_PRIO = 2'd2
   } arb_mode_e;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_ISSUE     = 2'd1,
      ARB_WAIT_DONE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/falafel_prio_picker.sv
// Combinational two-way grant between alloc and free, plus the starvation-counter update it implies.
// Mode 3 (and any unknown mode) falls back to round-robin.
module falafel_prio_picker
   import falafel_pkg::*;
(
   input  logic             alloc_vld,
   input  logic             free_vld,
   input  logic [1:0]       mode,
   input  core_op_e         last_grant,
   input  logic [CNT_W-1:0] starve_cnt,
   input  logic [CNT_W-1:0] starve_limit,
   output logic             grant_alloc,
   output logic             grant_free,
   output logic             starve_inc,
   output logic             starve_clr
);

   logic starved;
   assign starved = (starve_cnt >= starve_limit);

   always_comb begin
      grant_alloc = 1'b0;
      grant_free  = 1'b0;
      starve_inc  = 1'b0;
      starve_clr  = 1'b0;

      if (alloc_vld && free_vld) begin
         case (mode)
            ARB_FREE_PRIO: begin
               grant_alloc = starved;
               grant_free  = !starved;
            end
            ARB_ALLOC_PRIO: begin
               grant_free  = starved;
               grant_alloc = !starved;
            end
            default: begin
               grant_alloc = (last_grant == CORE_OP_FREE);
               grant_free  = (last_grant != CORE_OP_FREE);
            end
         endcase
      end else begin
         grant_alloc = alloc_vld;
         grant_free  = free_vld;
      end

      // Round-robin has no low-priority side, so the counter is left alone there.
      if (mode == ARB_FREE_PRIO) begin
         starve_clr = grant_alloc;
         starve_inc = grant_free && alloc_vld;
      end else if (mode == ARB_ALLOC_PRIO) begin
         starve_clr = grant_free;
         starve_inc = grant_alloc && free_vld;
      end
   end

endmodule

// File: rtl/falafel_req_arbiter.sv
// Arbitrates parser alloc/free requests into a single core request stream with one request outstanding.
// Handshake in cycle N presents core_req_val_o in N+1; inputs see rdy only while idle.
module falafel_req_arbiter
   import falafel_pkg::*;
#(
   parameter int DEFAULT_STARVE_LIMIT = 4,
   parameter int ARB_MODE_ADDR        = 0,
   parameter int STARVE_ADDR          = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       alloc_req_val_i,
   output logic                       alloc_req_rdy_o,
   input  logic [$bits(alloc_entry_t)-1:0] alloc_req_data_i,
   input  logic                       free_req_val_i,
   output logic                       free_req_rdy_o,
   input  logic [$bits(alloc_entry_t)-1:0] free_req_data_i,
   input  logic                       config_reg_write_i,
   input  logic [DATA_W-1:0]          config_reg_addr_i,
   input  logic [DATA_W-1:0]          config_reg_data_i,
   output logic                       core_req_val_o,
   input  logic                       core_req_rdy_i,
   output logic [$bits(core_req_t)-1:0] core_req_data_o,
   input  logic                       core_done_i,
   output logic                       busy_o
);

   arb_state_e       state_q, state_d;
   core_req_t        req_q;
   core_op_e         last_grant_q;
   logic [1:0]       mode_q;
   logic [CNT_W-1:0] starve_limit_q;
   logic [CNT_W-1:0] starve_cnt_q;

   logic grant_alloc, grant_free, starve_inc, starve_clr;
   logic handshake, mode_wr, limit_wr;
   core_op_e grant_op;

   falafel_prio_picker u_picker (
      .alloc_vld    (alloc_req_val_i),
      .free_vld     (free_req_val_i),
      .mode         (mode_q),
      .last_grant   (last_grant_q),
      .starve_cnt   (starve_cnt_q),
      .starve_limit (starve_limit_q),
      .grant_alloc  (grant_alloc),
      .grant_free   (grant_free),
      .starve_inc   (starve_inc),
      .starve_clr   (starve_clr)
   );

   assign handshake = (state_q == ARB_IDLE) && (grant_alloc || grant_free);
   assign grant_op  = grant_alloc ? CORE_OP_ALLOC : CORE_OP_FREE;
   assign mode_wr   = config_reg_write_i && (config_reg_addr_i == DATA_W'(ARB_MODE_ADDR));
   assign limit_wr  = config_reg_write_i && (config_reg_addr_i == DATA_W'(STARVE_ADDR));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= ARB_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      alloc_req_rdy_o = 1'b0;
      free_req_rdy_o  = 1'b0;
      core_req_val_o  = 1'b0;
      busy_o          = 1'b1;
      case (state_q)
         ARB_IDLE: begin
            busy_o          = 1'b0;
            alloc_req_rdy_o = grant_alloc;
            free_req_rdy_o  = grant_free;
            if (grant_alloc || grant_free) state_d = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            core_req_val_o = 1'b1;
            if (core_req_rdy_i) state_d = ARB_WAIT_DONE;
         end
         ARB_WAIT_DONE: begin
            if (core_done_i) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         req_q          <= '0;
         last_grant_q   <= CORE_OP_FREE;
         mode_q         <= ARB_RR;
         starve_limit_q <= CNT_W'(DEFAULT_STARVE_LIMIT);
         starve_cnt_q   <= '0;
      end else begin
         if (handshake) begin
            req_q.op     <= grant_op;
            req_q.entry  <= grant_alloc ? alloc_entry_t'(alloc_req_data_i)
                                        : alloc_entry_t'(free_req_data_i);
            last_grant_q <= grant_op;
         end
         // A mode change restarts fairness accounting even if a grant lands in the same cycle.
         if (mode_wr)
            starve_cnt_q <= '0;
         else if (handshake && starve_clr)
            starve_cnt_q <= '0;
         else if (handshake && starve_inc && (starve_cnt_q != '1))
            starve_cnt_q <= starve_cnt_q + 1'b1;
         if (mode_wr)  mode_q         <= config_reg_data_i[1:0];
         if (limit_wr) starve_limit_q <= config_reg_data_i[CNT_W-1:0];
      end
   end

   assign core_req_data_o = req_q;

   a_one_rdy: assert property (@(posedge clk_i) disable iff (!rst_ni)
                               !(alloc_req_rdy_o && free_req_rdy_o));

endmodule

// File: tb/tb_falafel_req_arbiter.sv
// Directed bench for falafel_req_arbiter: a grant vector table plus multi-cycle sequences.
module tb_falafel_req_arbiter;
   import falafel_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic alloc_req_val_i, alloc_req_rdy_o;
   logic [$bits(alloc_entry_t)-1:0] alloc_req_data_i;
   logic free_req_val_i, free_req_rdy_o;
   logic [$bits(alloc_entry_t)-1:0] free_req_data_i;
   logic config_reg_write_i;
   logic [DATA_W-1:0] config_reg_addr_i, config_reg_data_i;
   logic core_req_val_o, core_req_rdy_i, core_done_i, busy_o;
   logic [$bits(core_req_t)-1:0] core_req_data_o;

   int checks = 0;
   int errors = 0;

   falafel_req_arbiter dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .alloc_req_val_i    (alloc_req_val_i),
      .alloc_req_rdy_o    (alloc_req_rdy_o),
      .alloc_req_data_i   (alloc_req_data_i),
      .free_req_val_i     (free_req_val_i),
      .free_req_rdy_o     (free_req_rdy_o),
      .free_req_data_i    (free_req_data_i),
      .config_reg_write_i (config_reg_write_i),
      .config_reg_addr_i  (config_reg_addr_i),
      .config_reg_data_i  (config_reg_data_i),
      .core_req_val_o     (core_req_val_o),
      .core_req_rdy_i     (core_req_rdy_i),
      .core_req_data_o    (core_req_data_o),
      .core_done_i        (core_done_i),
      .busy_o             (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got running, expected done)");
      $fatal(1);
   end

   typedef struct {
      logic [1:0] mode;
      logic [7:0] lim;
      logic       av;
      logic       fv;
      logic       ea;
      logic       ef;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_ni             = 1'b0;
      alloc_req_val_i    = 1'b0;
      free_req_val_i     = 1'b0;
      alloc_req_data_i   = {4'd1, 8'h11};
      free_req_data_i    = {4'd2, 8'h22};
      config_reg_write_i = 1'b0;
      config_reg_addr_i  = '0;
      config_reg_data_i  = '0;
      core_req_rdy_i     = 1'b0;
      core_done_i        = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
      config_reg_write_i = 1'b1;
      config_reg_addr_i  = a;
      config_reg_data_i  = d;
      tick();
      config_reg_write_i = 1'b0;
   endtask

   // Called in ARB_ISSUE; returns in ARB_IDLE.
   task automatic finish_txn();
      core_req_rdy_i = 1'b1;
      tick();
      core_req_rdy_i = 1'b0;
      core_done_i    = 1'b1;
      tick();
      core_done_i    = 1'b0;
   endtask

   // Both sides valid throughout; bit i of exp_ops is the expected op of grant i (1 = FREE).
   task automatic grant_seq(input string name, input int n, input logic [15:0] exp_ops);
      core_req_t r;
      alloc_req_val_i = 1'b1;
      free_req_val_i  = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         r = core_req_t'(core_req_data_o);
         check($sformatf("%s_val%0d", name, i), {31'd0, core_req_val_o}, 32'd1);
         check($sformatf("%s_op%0d", name, i), {31'd0, r.op}, {31'd0, exp_ops[i]});
         finish_txn();
      end
      alloc_req_val_i = 1'b0;
      free_req_val_i  = 1'b0;
   endtask

   initial begin
      core_req_t exp_req;

      // mode, limit, alloc_v, free_v, expected alloc_rdy, expected free_rdy
      vecs[0]  = '{2'd0, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{2'd0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{2'd0, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{2'd0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'd1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{2'd1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{2'd2, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{2'd2, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{2'd3, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{2'd1, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{2'd2, 8'd4, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{2'd1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state
      do_reset();
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_val", {31'd0, core_req_val_o}, 32'd0);
      check("rst_data", 32'(core_req_data_o), 32'd0);
      check("rst_ardy", {31'd0, alloc_req_rdy_o}, 32'd0);
      check("rst_frdy", {31'd0, free_req_rdy_o}, 32'd0);

      // Single alloc request with core backpressure
      alloc_req_val_i  = 1'b1;
      alloc_req_data_i = {4'd3, 8'h40};
      #1;
      check("t1_ardy", {31'd0, alloc_req_rdy_o}, 32'd1);
      check("t1_frdy", {31'd0, free_req_rdy_o}, 32'd0);
      tick();
      alloc_req_val_i = 1'b0;
      exp_req.op       = CORE_OP_ALLOC;
      exp_req.entry.id = 4'd3;
      exp_req.entry.data = 8'h40;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t1_hold_val%0d", i), {31'd0, core_req_val_o}, 32'd1);
         check($sformatf("t1_hold_data%0d", i), 32'(core_req_data_o), 32'(exp_req));
         check($sformatf("t1_hold_ardy%0d", i), {31'd0, alloc_req_rdy_o}, 32'd0);
         tick();
      end
      core_req_rdy_i = 1'b1;
      tick();
      core_req_rdy_i = 1'b0;
      check("t1_wait_val", {31'd0, core_req_val_o}, 32'd0);
      check("t1_wait_busy", {31'd0, busy_o}, 32'd1);
      core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      check("t1_done_busy", {31'd0, busy_o}, 32'd0);

      // Grant table, each from a fresh reset
      foreach (vecs[k]) begin
         do_reset();
         cfg_write(8'd0, {6'd0, vecs[k].mode});
         cfg_write(8'd1, vecs[k].lim);
         alloc_req_val_i = vecs[k].av;
         free_req_val_i  = vecs[k].fv;
         #1;
         check($sformatf("vec%0d_ardy", k), {31'd0, alloc_req_rdy_o}, {31'd0, vecs[k].ea});
         check($sformatf("vec%0d_frdy", k), {31'd0, free_req_rdy_o}, {31'd0, vecs[k].ef});
         tick();
         alloc_req_val_i = 1'b0;
         free_req_val_i  = 1'b0;
         check($sformatf("vec%0d_val", k), {31'd0, core_req_val_o}, {31'd0, vecs[k].ea | vecs[k].ef});
         if (vecs[k].ea || vecs[k].ef) begin
            exp_req.op    = vecs[k].ef ? CORE_OP_FREE : CORE_OP_ALLOC;
            exp_req.entry = vecs[k].ef ? alloc_entry_t'({4'd2, 8'h22}) : alloc_entry_t'({4'd1, 8'h11});
            check($sformatf("vec%0d_data", k), 32'(core_req_data_o), 32'(exp_req));
            finish_txn();
         end else begin
            check($sformatf("vec%0d_busy", k), {31'd0, busy_o}, 32'd0);
         end
      end

      // Round-robin alternation
      do_reset();
      grant_seq("rr", 4, 16'b1010);

      // Free priority with starvation limit 2
      do_reset();
      cfg_write(8'd0, 8'd1);
      cfg_write(8'd1, 8'd2);
      grant_seq("fprio", 6, 16'b011011);

      // Unmapped address leaves mode and limit alone
      do_reset();
      cfg_write(8'd5, 8'hFF);
      grant_seq("badaddr", 4, 16'b1010);

      // Mode write in the same cycle as a grant does not affect that grant
      do_reset();
      cfg_write(8'd0, 8'd1);
      alloc_req_val_i    = 1'b1;
      free_req_val_i     = 1'b1;
      config_reg_write_i = 1'b1;
      config_reg_addr_i  = 8'd0;
      config_reg_data_i  = 8'd2;
      #1;
      check("samecyc_frdy", {31'd0, free_req_rdy_o}, 32'd1);
      check("samecyc_ardy", {31'd0, alloc_req_rdy_o}, 32'd0);
      tick();
      config_reg_write_i = 1'b0;
      finish_txn();
      #1;
      check("newmode_ardy", {31'd0, alloc_req_rdy_o}, 32'd1);
      alloc_req_val_i = 1'b0;
      free_req_val_i  = 1'b0;

      // Done during ISSUE, including alongside core ready, is ignored
      do_reset();
      alloc_req_val_i = 1'b1;
      tick();
      alloc_req_val_i = 1'b0;
      core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      check("issdone_val", {31'd0, core_req_val_o}, 32'd1);
      core_req_rdy_i = 1'b1;
      core_done_i    = 1'b1;
      tick();
      core_req_rdy_i = 1'b0;
      core_done_i    = 1'b0;
      check("issdone_wait_val", {31'd0, core_req_val_o}, 32'd0);
      check("issdone_wait_busy", {31'd0, busy_o}, 32'd1);
      tick();
      tick();
      check("issdone_still_busy", {31'd0, busy_o}, 32'd1);
      core_done_i = 1'b1;
      tick();
      core_done_i = 1'b0;
      check("issdone_idle", {31'd0, busy_o}, 32'd0);

      // Reset while waiting for done
      do_reset();
      cfg_write(8'd0, 8'd1);
      alloc_req_val_i = 1'b1;
      free_req_val_i  = 1'b1;
      tick();
      alloc_req_val_i = 1'b0;
      free_req_val_i  = 1'b0;
      core_req_rdy_i  = 1'b1;
      tick();
      core_req_rdy_i = 1'b0;
      check("midrst_pre_busy", {31'd0, busy_o}, 32'd1);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      check("midrst_val", {31'd0, core_req_val_o}, 32'd0);
      check("midrst_busy", {31'd0, busy_o}, 32'd0);
      check("midrst_data", 32'(core_req_data_o), 32'd0);
      tick();
      check("midrst_noval", {31'd0, core_req_val_o}, 32'd0);
      alloc_req_val_i = 1'b1;
      free_req_val_i  = 1'b1;
      #1;
      check("midrst_ardy", {31'd0, alloc_req_rdy_o}, 32'd1);
      check("midrst_frdy", {31'd0, free_req_rdy_o}, 32'd0);
      tick();
      alloc_req_val_i = 1'b0;
      free_req_val_i  = 1'b0;
      exp_req.op    = CORE_OP_ALLOC;
      exp_req.entry = alloc_entry_t'({4'd1, 8'h11});
      check("midrst_grant", 32'(core_req_data_o), 32'(exp_req));
      finish_txn();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/falafel_req_arbiter.md
Name: falafel_req_arbiter

Overview:
- Sits directly downstream of the input parser.
- Consumes its two request streams: alloc and free, each an alloc_entry_t over valid/ready.
- Consumes its config-register write strobe.
- Arbitrates the two streams into one request stream toward the allocator core, allowing one outstanding request.
- Holds the arbitration-policy registers written through the config path.

Parameters:
- DEFAULT_STARVE_LIMIT, 4: reset value of the starvation limit register (8 bits).
- ARB_MODE_ADDR, 0: config address of the arbitration-mode register.
- STARVE_ADDR, 1: config address of the starvation-limit register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- alloc_req_val_i  in  1  alloc request valid
- alloc_req_rdy_o  out  1  alloc request ready
- alloc_req_data_i  in  $bits(alloc_entry_t)  alloc request {id, data}
- free_req_val_i  in  1  free request valid
- free_req_rdy_o  out  1  free request ready
- free_req_data_i  in  $bits(alloc_entry_t)  free request {id, data}
- config_reg_write_i  in  1  single-cycle config write strobe
- config_reg_addr_i  in  DATA_W  config register address
- config_reg_data_i  in  DATA_W  config write data
- core_req_val_o  out  1  core request valid
- core_req_rdy_i  in  1  core request ready
- core_req_data_o  out  $bits(core_req_t)  {op, entry}; op = CORE_OP_ALLOC or CORE_OP_FREE
- core_done_i  in  1  single-cycle pulse: core finished the outstanding request
- busy_o  out  1  high whenever state != ARB_IDLE

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values:
  - state ARB_IDLE, so all outputs low: core_req_val_o=0, busy_o=0, both rdy_o=0 unless a grant is computed.
  - core_req_data_o = 0.
  - mode = RR (0).
  - starve_limit = DEFAULT_STARVE_LIMIT.
  - last_grant = FREE, so alloc wins the first RR tie.
  - starve_cnt = 0.
- Reset mid-operation drops any captured request silently; no core_req_val_o in the cycle after reset.
- State machine:
  - ARB_IDLE: compute the grant combinationally from the valids, mode and starve_cnt.
    - Assert only the winner's rdy_o. This is the only state in which any rdy_o can be high.
    - On handshake: capture {op, entry} into the output register and go to ARB_ISSUE.
    - No valids: stay in ARB_IDLE.
  - ARB_ISSUE: core_req_val_o=1 with stable data.
    - On core_req_rdy_i, go to ARB_WAIT_DONE.
    - core_done_i in this state is ignored.
  - ARB_WAIT_DONE: core_req_val_o=0.
    - On core_done_i, go to ARB_IDLE.
    - Next grant no earlier than the cycle after done.
- Latency: input handshake in cycle N gives core_req_val_o in N+1. Minimum turnaround is 3 cycles per request (IDLE, ISSUE, WAIT_DONE with immediate done).
- Grant rules:
  - Only one valid: that side wins, in any mode.
  - Both valid, RR (mode 0): the side opposite last_grant wins.
  - Both valid, FREE_PRIO (mode 1): free wins, unless starve_cnt >= starve_limit, in which case alloc wins.
  - Both valid, ALLOC_PRIO (mode 2): mirror of FREE_PRIO.
  - Mode 3: treated as RR.
- starve_cnt:
  - Increments, saturating at 255, on each grant where the low-priority side was valid and lost.
  - Clears on any grant to the low-priority side.
  - Clears on a mode write.
- starve_limit=0 makes the low-priority side win every contested grant (degenerates to inverted priority).
- last_grant updates on every grant.
- Config writes, accepted in any state:
  - addr == ARB_MODE_ADDR: mode <= data[1:0].
  - addr == STARVE_ADDR: starve_limit <= data[7:0].
  - Other addresses are ignored.
- A write takes effect for arbitration in the cycle after the strobe. A write in the same cycle as an IDLE grant does not affect that grant.
- Simultaneous valids on both inputs in IDLE: exactly one rdy_o high. Both rdy_o high is illegal (assertion).

Decomposition:
- falafel_pkg additions:
  - core_op_e (CORE_OP_ALLOC, CORE_OP_FREE)
  - core_req_t {core_op_e op; alloc_entry_t entry}
  - arb_mode_e (ARB_RR, ARB_FREE_PRIO, ARB_ALLOC_PRIO)
  - arb_state_e
- Optional sub-module falafel_prio_picker: combinational two-way grant from valids, mode, last_grant, starve_cnt and starve_limit, so it can be tested exhaustively on its own.

Test Plan:
- Reset, then alloc valid with id=3, data=0x40 -> alloc_req_rdy_o=1 in cycle 0, core_req_val_o=1 in cycle 1 with op=ALLOC, entry {3,0x40}. Hold core_req_rdy_i=0 for 3 cycles -> data stays stable. Pulse done -> busy_o falls.
- RR mode, both valid continuously, core_req_rdy_i=1, done 1 cycle after acceptance -> grant order ALLOC, FREE, ALLOC, FREE.
- Write addr 0 data 1 and addr 1 data 2; both valid continuously -> grant order FREE, FREE, ALLOC, FREE, FREE, ALLOC.
- Pulse core_done_i during ARB_ISSUE -> ignored; state reaches WAIT_DONE and waits for a later done.
- Assert rst_ni=0 during ARB_WAIT_DONE -> next cycle all outputs at reset values, mode back to RR, first contested grant to ALLOC.
- Write addr 5 data 0xFF -> mode and starve_limit unchanged; RR order preserved.
